// File: rtl/gcd_driver.sv
// gcd_driver: sequences one operand pair at a time into an external GCD engine
// and presents the result downstream.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
// valid and ready are both 1. A producer holds valid and its data steady until
// that edge. The input side is ready only in IDLE. The output side holds
// out_valid, out_result and out_err stable in RESP until out_ready is seen.
//
// Optional feature: define GCD_DRV_TIMEOUT_EN to abort a WAIT after TIMEOUT
// cycles without eng_done. An aborted result has out_result=0 and out_err=1.
// Without the macro, WAIT lasts until eng_done and out_err is constant 0.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b operand pair input
//   eng_start, eng_data         engine load: start pulse with A, then B
//   eng_done, eng_result        engine completion level and result
//   out_valid/out_ready         result output handshake
//   out_result, out_err         result value and timeout-abort flag
//   busy                        high whenever the FSM is not IDLE
//   op_count                    completed results, wraps 255->0
module gcd_driver #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_data,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic             busy,
  output logic [7:0]       op_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [7:0]       op_cnt_q, op_cnt_d;

`ifdef GCD_DRV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    op_cnt_d = op_cnt_q;
`ifdef GCD_DRV_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // in_ready is 1 throughout IDLE, so in_valid alone means acceptance.
        if (in_valid) begin
          a_d = in_a;
          b_d = in_b;
          if (in_a != '0 && in_b != '0) begin
            state_d = ST_LOAD_A;
          end else begin
            // gcd(0,x)=x and gcd(0,0)=0; the engine is not needed.
            res_d   = (in_a == '0) ? in_b : in_a;
`ifdef GCD_DRV_TIMEOUT_EN
            err_d   = 1'b0;
`endif
            state_d = ST_RESP;
          end
        end
      end
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: begin
`ifdef GCD_DRV_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // eng_done is checked first so that a completion in the same cycle
        // as the timeout still delivers the real result.
        if (eng_done) begin
          res_d   = eng_result;
`ifdef GCD_DRV_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ST_RESP;
        end
`ifdef GCD_DRV_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th WAIT cycle without completion.
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RESP: begin
        if (out_ready) begin
          op_cnt_d = op_cnt_q + 8'd1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      op_cnt_q <= '0;
`ifdef GCD_DRV_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      op_cnt_q <= op_cnt_d;
`ifdef GCD_DRV_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // All outputs come from state or registers only.
  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign eng_start  = (state_q == ST_LOAD_A);
  // A during LOAD_A, otherwise B. B stays on the bus through WAIT, and both
  // latched operands are zero after reset.
  assign eng_data   = (state_q == ST_LOAD_A) ? a_q : b_q;
  assign out_valid  = (state_q == ST_RESP);
  assign out_result = res_q;
  assign op_count   = op_cnt_q;

`ifdef GCD_DRV_TIMEOUT_EN
  assign out_err = err_q;
`else
  // TIMEOUT has no effect in this build; this expression is the constant 0.
  assign out_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_gcd_driver.sv
module tb_gcd_driver;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             eng_start;
  logic [WIDTH-1:0] eng_data;
  logic             eng_done;
  logic [WIDTH-1:0] eng_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_err;
  logic             busy;
  logic [7:0]       op_count;

  gcd_driver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .eng_start  (eng_start),
    .eng_data   (eng_data),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .busy       (busy),
    .op_count   (op_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cyc = 0;
  int exp_cnt = 0;
  int eng_delay = 1;
  bit eng_hang = 1'b0;
  logic [WIDTH-1:0] cap_a, cap_b;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (eng_start === 1'b1) start_cnt <= start_cnt + 1;

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- engine model ----------------
  // Captures A then B from the load bus, then after eng_delay cycles raises
  // eng_done for one cycle with the gcd of what it captured.
  initial begin : engine
    eng_done   = 1'b0;
    eng_result = '0;
    forever begin
      @(posedge clk); #1;
      if (eng_start === 1'b1 && !eng_hang) begin
        cap_a = eng_data;
        @(posedge clk); #1;
        cap_b = eng_data;
        repeat (eng_delay) @(posedge clk);
        #1;
        eng_done   = 1'b1;
        eng_result = ref_gcd(cap_a, cap_b);
        done_cyc   = cyc + 1;
        @(posedge clk); #1;
        eng_done   = 1'b0;
        eng_result = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_values(input string tag);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_data"}, eng_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_result"}, out_result, 0);
    chk({tag, "_out_err"}, out_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_op_count"}, op_count, 0);
  endtask

  task automatic accept_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = WIDTH'($urandom);
    in_b     = WIDTH'($urandom);
  endtask

  task automatic finish_resp();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    chk("op_count", op_count, exp_cnt);
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_ready", in_ready, 1);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int delay, input int hold);
    logic [WIDTH-1:0] exp_r;
    int s0;
    int n;
    bit bypass;
    exp_r     = ref_gcd(a, b);
    bypass    = (a == 0) || (b == 0);
    eng_delay = delay;
    s0        = start_cnt;
    accept_pair(a, b);
    if (bypass) begin
      chk("bypass_valid", out_valid, 1);
    end else begin
      chk("load_a_start", eng_start, 1);
      chk("load_a_data", eng_data, a);
      @(posedge clk); #1;
      chk("load_b_start", eng_start, 0);
      chk("load_b_data", eng_data, b);
      n = 0;
      while (out_valid !== 1'b1 && n < 60) begin
        @(posedge clk); #1;
        n++;
      end
      chk("resp_wait", out_valid, 1);
      chk("done_latency", cyc, done_cyc);
    end
    chk("result", out_result, exp_r);
    chk("err", out_err, 0);
    chk("resp_in_ready", in_ready, 0);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", out_result, exp_r);
      chk("hold_in_ready", in_ready, 0);
    end
    finish_resp();
    chk("start_pulses", start_cnt - s0, bypass ? 0 : 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin : main
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Known-answer operation and bypass cases
    do_op(16'd143, 16'd78, 3, 0);
    chk("first_op_count", op_count, 1);
    do_op(16'd0, 16'd25, 1, 0);
    do_op(16'd0, 16'd0, 1, 0);
    do_op(16'd40, 16'd0, 1, 0);

    // Downstream back-pressure for 10 cycles
    do_op(16'd100, 16'd75, 2, 10);

    // Randomized operands with random engine delay and back-pressure
    for (int i = 0; i < 24; i++) begin
      int mode;
      int f;
      logic [WIDTH-1:0] ra, rb;
      mode = $urandom_range(0, 5);
      f    = $urandom_range(1, 60);
      ra   = WIDTH'(f * $urandom_range(1, 1000));
      rb   = WIDTH'(f * $urandom_range(1, 1000));
      if (mode == 0) ra = '0;
      if (mode == 1) rb = '0;
      do_op(ra, rb, $urandom_range(1, 6), $urandom_range(0, 3));
    end

`ifdef GCD_DRV_TIMEOUT_EN
    // Engine never answers: abort after TIMEOUT WAIT cycles
    eng_hang = 1'b1;
    accept_pair(16'd7, 16'd5);
    repeat (TIMEOUT + 1) @(posedge clk);
    #1;
    chk("timeout_not_early", out_valid, 0);
    @(posedge clk); #1;
    chk("timeout_valid", out_valid, 1);
    chk("timeout_err", out_err, 1);
    chk("timeout_result", out_result, 0);
    finish_resp();
    accept_pair(16'd9, 16'd6);
    repeat (3) @(posedge clk);
    #1;
`else
    // Engine never answers: WAIT persists
    eng_hang = 1'b1;
    accept_pair(16'd7, 16'd5);
    repeat (100) @(posedge clk);
    #1;
    chk("no_timeout_valid", out_valid, 0);
    chk("no_timeout_busy", busy, 1);
    chk("no_timeout_ready", in_ready, 0);
`endif

    // Reset in the middle of WAIT discards the operation
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midwait_rst");
    exp_cnt = 0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    eng_hang = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    do_op(16'd48, 16'd18, 2, 0);

    // 256 back-to-back operations wrap op_count to 0
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      do_op(16'd12, 16'd8, 1, 0);
    end
    chk("op_count_wrap", op_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_driver.md
GCD_DRIVER -- requirements
Module: gcd_driver

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits.
REQ-002 Parameter: TIMEOUT, 4095, maximum WAIT cycles before abort (used only with GCD_DRV_TIMEOUT_EN).
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  upstream operand pair valid.
REQ-006 Port: in_ready  output  1  driver can accept a pair.
REQ-007 Port: in_a  input  WIDTH  operand A.
REQ-008 Port: in_b  input  WIDTH  operand B.
REQ-009 Port: eng_start  output  1  one-cycle start pulse to the GCD engine.
REQ-010 Port: eng_data  output  WIDTH  engine load bus: A in the start cycle, B in the next cycle.
REQ-011 Port: eng_done  input  1  engine result-ready level.
REQ-012 Port: eng_result  input  WIDTH  engine result, valid while eng_done=1.
REQ-013 Port: out_valid  output  1  result available downstream.
REQ-014 Port: out_ready  input  1  downstream accepts the result.
REQ-015 Port: out_result  output  WIDTH  GCD result.
REQ-016 Port: out_err  output  1  result aborted by timeout.
REQ-017 Port: busy  output  1  high in any state other than IDLE.
REQ-018 Port: op_count  output  8  count of completed results, wrapping at 255->0.

Function
REQ-019 States SHALL be IDLE, LOAD_A, LOAD_B, WAIT and RESP; in_ready SHALL be 1 only in IDLE.
REQ-020 IDLE: on in_valid&in_ready, in_a and in_b SHALL be latched; if both are nonzero, the next state SHALL be LOAD_A, otherwise the bypass path (REQ-025) SHALL apply.
REQ-021 LOAD_A (1 cycle): eng_start=1 and eng_data=A; the next state SHALL be LOAD_B.
REQ-022 LOAD_B (1 cycle): eng_start=0 and eng_data=B; the next state SHALL be WAIT.
REQ-023 WAIT: eng_data SHALL hold B; eng_done SHALL be ignored in LOAD_A and LOAD_B; on the first sampled eng_done=1, eng_result SHALL be captured into out_result and the next state SHALL be RESP.
REQ-024 RESP: out_valid=1; out_result and out_err SHALL be stable until out_valid&out_ready; on handshake, op_count SHALL increment and the next state SHALL be IDLE.
REQ-025 Bypass: if A=0, out_result SHALL be B; if B=0, out_result SHALL be A; if both are 0, out_result SHALL be 0; the engine is not started and RESP is entered on the cycle after acceptance.
REQ-026 Latency: acceptance at edge N puts eng_start high in cycle N+1; eng_done sampled at edge M puts out_valid high in cycle M+1.
REQ-027 in_ready SHALL be 0 in RESP, so a new acceptance is possible no earlier than the cycle after the out handshake.
REQ-028 eng_start SHALL never be asserted outside LOAD_A.
REQ-029 Outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from in_valid or out_ready to outputs other than through state.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, eng_start=0, eng_data=0, out_valid=0, out_result=0, out_err=0, busy=0, op_count=0 and the latched operands=0.
REQ-031 in_ready SHALL be 1 from the first cycle after rst_n deasserts.
REQ-032 Reset in any state, including mid-WAIT, SHALL discard the operation; no result SHALL be emitted and op_count SHALL not increment.

Configuration
REQ-033 Macro GCD_DRV_TIMEOUT_EN defined: a counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-034 With GCD_DRV_TIMEOUT_EN defined: if the count reaches TIMEOUT with eng_done still 0, the next state SHALL be RESP with out_result=0 and out_err=1.
REQ-035 With GCD_DRV_TIMEOUT_EN defined: if eng_done=1 in the same cycle the timeout is reached, eng_done SHALL win and out_err SHALL be 0.
REQ-036 Macro GCD_DRV_TIMEOUT_EN undefined: WAIT SHALL persist until eng_done, out_err SHALL be tied to 0, and no counter logic SHALL be present.

Verification
REQ-037 A=143, B=78, engine model asserts done with 13 -> eng_data sequence 143 then 78, one eng_start pulse, out_result=13, out_err=0, op_count=1.
REQ-038 A=0, B=25 -> no eng_start, out_valid in the cycle after acceptance, out_result=25; A=0, B=0 -> out_result=0.
REQ-039 out_ready held 0 for 10 cycles in RESP -> out_valid and out_result stable, in_ready=0, then one handshake increments op_count by 1.
REQ-040 Macro defined, TIMEOUT=8, engine never asserts done -> RESP after 8 WAIT cycles with out_err=1 and out_result=0; macro undefined -> still in WAIT after 100 cycles.
REQ-041 rst_n pulsed low during WAIT -> all outputs at reset values, no out_valid, then a new pair 48,18 -> out_result=6.
REQ-042 256 back-to-back pairs (12,8) -> every out_result=4 and op_count wraps to 0.
